aes128_gf_mult: RTL and testbench



---
 rtl/aes128_type_pkg.sv | 19 +
 rtl/aes128_gf_mult.sv | 115 +++++++++++
 tb/tb_aes128_gf_mult.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_type_pkg.sv
// Shared AES types and helpers: the reduction polynomial constant,
// the GF(2^8) multiplier state encoding and a reusable xtime function.
package aes128_type_pkg;

    // Low byte of x^8+x^4+x^3+x+1; the x^8 term is implied by the shift-out.
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gmul_state_e;

    // Multiply by x in GF(2^8): shift left, fold bit 7 back in with poly.
    function automatic logic [7:0] xtime(input logic [7:0] a, input logic [7:0] poly);
        return {a[6:0], 1'b0} ^ (a[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_gf_mult.sv
// Sequential shift-and-add GF(2^8) multiplier, one bit of b per cycle.
// Optional build macro AES128_GMUL_EARLY_EXIT_EN: when defined, CALC stops
// as soon as the remaining multiplier bits are all zero; otherwise CALC
// always performs exactly eight iterations (constant latency of 10).
module aes128_gf_mult
    import aes128_type_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       start_i,
    output logic [7:0] result_o,
    output logic       valid_o
);

    gmul_state_e state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  result_q, result_d;
    logic        calc_exit;

`ifdef AES128_GMUL_EARLY_EXIT_EN
    // Nothing left to add once every remaining multiplier bit is zero.
    assign calc_exit = (b_q == 8'h00);
`else
    logic [2:0]  cnt_q, cnt_d;
    logic        last_q, last_d;

    // last_q is raised by the eighth iteration, so the following CALC cycle exits.
    assign calc_exit = last_q;
`endif

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        result_d = result_q;
`ifndef AES128_GMUL_EARLY_EXIT_EN
        cnt_d    = cnt_q;
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    p_d     = 8'h00;
                    state_d = CALC;
`ifndef AES128_GMUL_EARLY_EXIT_EN
                    cnt_d   = 3'd0;
                    last_d  = 1'b0;
`endif
                end
            end
            CALC: begin
                if (calc_exit) begin
                    result_d = p_q;
                    state_d  = DONE;
                end else begin
                    if (b_q[0]) begin
                        p_d = p_q ^ a_q;
                    end
                    a_d = xtime(a_q, POLY);
                    b_d = {1'b0, b_q[7:1]};
`ifndef AES128_GMUL_EARLY_EXIT_EN
                    cnt_d  = cnt_q + 3'd1;
                    last_d = (cnt_q == 3'd7);
`endif
                end
            end
            DONE: begin
                // start_i is deliberately not looked at here; IDLE samples it next cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            p_q      <= 8'h00;
            result_q <= 8'h00;
`ifndef AES128_GMUL_EARLY_EXIT_EN
            cnt_q    <= 3'd0;
            last_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            result_q <= result_d;
`ifndef AES128_GMUL_EARLY_EXIT_EN
            cnt_q    <= cnt_d;
            last_q   <= last_d;
`endif
        end
    end

    assign result_o = result_q;
    assign valid_o  = (state_q == DONE);

endmodule

// File: tb/tb_aes128_gf_mult.sv
// Self-checking bench for aes128_gf_mult: a polynomial-arithmetic reference
// model predicts each product and the cycle its valid pulse must appear in.
module tb_aes128_gf_mult;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       valid;

    typedef struct {
        logic [7:0] res;
        int         due;
    } exp_t;

    exp_t       expq[$];
    int         cyc     = 0;
    logic       rst_s   = 1'b0;
    int         n_cmp   = 0;
    int         n_fail  = 0;
    logic [7:0] exp_res = 8'h00;
    logic [7:0] xacc    = 8'h00;
    int         vcnt    = 0;

    aes128_gf_mult dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .a_i     (a),
        .b_i     (b),
        .start_i (start),
        .result_o(result),
        .valid_o (valid)
    );

    always #5 clk = ~clk;

    // Carry-less full product, then long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (y[i]) prod ^= (16'(x) << i);
        for (int k = 15; k >= 8; k--)
            if (prod[k]) prod ^= (16'h011B << (k - 8));
        return prod[7:0];
    endfunction

    // Cycles from the sampling cycle to the valid cycle.
    function automatic int lat(input logic [7:0] y);
`ifdef AES128_GMUL_EARLY_EXIT_EN
        int n;
        n = 0;
        for (int i = 0; i < 8; i++)
            if (y[i]) n = i + 1;
        return n + 2;
`else
        return 10;
`endif
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    // Compare process: every cycle, valid_o and result_o against the model.
    always @(negedge clk) begin : cmp
        logic ev;
        ev = 1'b0;
        if (rst_s) begin
            expq.delete();
            exp_res = 8'h00;
        end
        if (expq.size() > 0 && expq[0].due < cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL lost_expectation: due %0d, now %0d", expq[0].due, cyc);
            void'(expq.pop_front());
        end
        if (expq.size() > 0 && expq[0].due == cyc) begin
            ev      = 1'b1;
            exp_res = expq[0].res;
            void'(expq.pop_front());
        end
        chk("valid_o", {7'b0, valid}, {7'b0, ev});
        chk("result_o", result, exp_res);
        if (valid === 1'b1) begin
            xacc ^= result;
            vcnt++;
        end
    end

    // Drive a request whose start_i is sampled at the end of cycle t.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input int t, output int due);
        exp_t e;
        a     = x;
        b     = y;
        start = 1'b1;
        due   = t + lat(y);
        e.res = gf_ref(x, y);
        e.due = due;
        expq.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit noise);
        int due;
        @(negedge clk);
        issue(x, y, cyc, due);
        @(negedge clk);
        while (cyc < due) begin
            if (noise) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // start_i held high; operands swap in the valid cycle of the previous op.
    task automatic do_chain(input logic [7:0] xs[$], input logic [7:0] ys[$]);
        int due;
        @(negedge clk);
        issue(xs[0], ys[0], cyc, due);
        for (int i = 1; i < xs.size(); i++) begin
            wait_cyc(due);
            issue(xs[i], ys[i], due + 1, due);
        end
        wait_cyc(due);
        start = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : drv
        logic [7:0] xs[$];
        logic [7:0] ys[$];
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Pin the reference model with hand-computed products.
        chk("model_57x83", gf_ref(8'h57, 8'h83), 8'hC1);
        chk("model_57x13", gf_ref(8'h57, 8'h13), 8'hFE);
        chk("model_87x02", gf_ref(8'h87, 8'h02), 8'h15);
        chk("model_D4x02", gf_ref(8'hD4, 8'h02), 8'hB3);
        chk("model_BFx03", gf_ref(8'hBF, 8'h03), 8'hDA);
`ifdef AES128_GMUL_EARLY_EXIT_EN
        chk("lat_b00", 8'(lat(8'h00)), 8'd2);
        chk("lat_b02", 8'(lat(8'h02)), 8'd4);
        chk("lat_b0E", 8'(lat(8'h0E)), 8'd6);
`else
        chk("lat_const", 8'(lat(8'h83)), 8'd10);
`endif

        // Directed vectors.
        do_op(8'h57, 8'h83, 1'b0);
        do_op(8'h57, 8'h13, 1'b0);
        do_op(8'h57, 8'h02, 1'b0);
        do_op(8'h87, 8'h02, 1'b0);
        do_op(8'hFF, 8'h00, 1'b0);
        do_op(8'h00, 8'hA5, 1'b0);
        do_op(8'h3C, 8'h01, 1'b0);

        // MixColumns column byte with start_i held high.
        @(negedge clk);
        xacc = 8'h00;
        vcnt = 0;
        xs = '{8'hD4, 8'hBF, 8'h5D, 8'h30};
        ys = '{8'h02, 8'h03, 8'h01, 8'h01};
        do_chain(xs, ys);
        repeat (2) @(negedge clk);
        chk("mixcol_xor", xacc, 8'h04);
        chk("mixcol_count", 8'(vcnt), 8'd4);

        // Operand and start noise while busy.
        do_op(8'h57, 8'h83, 1'b1);
        do_op(8'h87, 8'h02, 1'b1);
        do_op(8'hFF, 8'h00, 1'b1);

        // Abort in the second CALC cycle after a nonzero result is on result_o.
        do_op(8'h57, 8'h83, 1'b0);
        @(negedge clk);
        a     = 8'hCA;
        b     = 8'h83;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h11;
        b     = 8'h22;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("result_after_abort", result, 8'h00);
        do_op(8'h57, 8'h13, 1'b0);

        // Randomized singles and held-start chains.
        for (int n = 0; n < 120; n++) begin
            logic [7:0] ry;
            case ($urandom_range(0, 3))
                0:       ry = 8'($urandom_range(0, 3));
                1:       ry = 8'h80;
                default: ry = 8'($urandom);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                xs.delete();
                ys.delete();
                for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                    xs.push_back(8'($urandom));
                    ys.push_back(8'($urandom));
                end
                do_chain(xs, ys);
            end else begin
                do_op(8'($urandom), ry, 1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 8'(expq.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
